// File: rtl/shift_reg_univ.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : shift_reg_univ                                             |
// | Description : Universal shift register with shift/load/clear, optional   |
// |               rotate (macro SHIFT_REG_ROTATE_EN) and counted burst mode. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module shift_reg_univ #(
  parameter int WIDTH = 10,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CW-1:0]    count,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] c_MODE_HOLD = 3'd0;
  localparam logic [2:0] c_MODE_SHL  = 3'd1;
  localparam logic [2:0] c_MODE_SHR  = 3'd2;
  localparam logic [2:0] c_MODE_LOAD = 3'd3;
  localparam logic [2:0] c_MODE_ROL  = 3'd4;
  localparam logic [2:0] c_MODE_ROR  = 3'd5;
  localparam logic [2:0] c_MODE_CLR  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [CW-1:0]    r_rem;
  logic [2:0]       r_run_mode;
  logic [2:0]       w_op;
  logic             w_accept;

  // Next state and the operation applied at this edge. Accepting a burst and
  // the DONE cycle both force HOLD so q never moves outside the burst window.
  always_comb begin
    w_next_state = r_state;
    w_op         = c_MODE_HOLD;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = (count == '0) ? S_DONE : S_RUN;
        end else begin
          w_op = mode;
        end
      end
      S_RUN: begin
        w_op = r_run_mode;
        if (r_rem == CW'(1)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Without the rotate option, modes 4/5 fall through to HOLD.
  always_comb begin
    w_q_next = r_q;
    case (w_op)
      c_MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], ser_in_l};
      c_MODE_SHR:  w_q_next = {ser_in_r, r_q[WIDTH-1:1]};
      c_MODE_LOAD: w_q_next = par_in;
`ifdef SHIFT_REG_ROTATE_EN
      c_MODE_ROL:  w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      c_MODE_ROR:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
`endif
      c_MODE_CLR:  w_q_next = '0;
      default:     w_q_next = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  // Exit is taken at rem==1, so the decrement never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem      <= '0;
      r_run_mode <= c_MODE_HOLD;
    end else if (w_accept) begin
      r_rem      <= count;
      r_run_mode <= mode;
    end else if (r_state == S_RUN) begin
      r_rem <= r_rem - CW'(1);
    end
  end

  assign q         = r_q;
  assign ser_out_l = r_q[WIDTH-1];
  assign ser_out_r = r_q[0];
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire
